z80_wb_router: RTL and testbench

//  Parametrised Wishbone classic router between the z80 core master port and NSLV slaves
//  (on-board SRAM, BIST/IO peripherals, external bus). It decodes address+tag and routes

---
 rtl/z80_wb_router_pkg.sv | 20 ++
 rtl/z80_wb_addr_dec.sv | 41 ++++
 rtl/z80_wb_router.sv | 206 ++++++++++++++++++++
 tb/tb_z80_wb_router.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/z80_wb_router_pkg.sv
// rtl/z80_wb_router_pkg.sv - shared types for the z80 Wishbone router
package z80_wb_router_pkg;

    // Router transaction state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Z80 address tag codes carried on wb_tga
    typedef enum logic [1:0] {
        TGA_MEM = 2'b00,
        TGA_IO  = 2'b01,
        TGA_INT = 2'b10
    } tga_e;

    localparam int CNT_W = 8;

endpackage

// File: rtl/z80_wb_addr_dec.sv
// rtl/z80_wb_addr_dec.sv - combinational priority address/tag decoder
//
// Ports:
//   adr_i  ADR_W   master address
//   tga_i  TGA_W   master address tag
//   sel_o  NSLV    one-hot selected slot
//   idx_o  IDX_W   binary index of selected slot
// Slot NSLV-1 is the catch-all; its BASE/MASK/TGA are never compared.
module z80_wb_addr_dec #(
    parameter int                      NSLV  = 3,
    parameter int                      ADR_W = 16,
    parameter int                      TGA_W = 2,
    parameter int                      IDX_W = 2,
    parameter logic [NSLV*ADR_W-1:0]   BASE  = '0,
    parameter logic [NSLV*ADR_W-1:0]   MASK  = '0,
    parameter logic [NSLV*TGA_W-1:0]   TGA   = '0
) (
    input  logic [ADR_W-1:0] adr_i,
    input  logic [TGA_W-1:0] tga_i,
    output logic [NSLV-1:0]  sel_o,
    output logic [IDX_W-1:0] idx_o
);

    logic found;

    always_comb begin
        found = 1'b0;
        idx_o = IDX_W'(NSLV - 1);
        // Ascending scan; the first hit locks so the lowest index wins
        for (int i = 0; i < NSLV - 1; i++) begin
            if (!found
                && ((adr_i & MASK[i*ADR_W +: ADR_W]) == BASE[i*ADR_W +: ADR_W])
                && (tga_i == TGA[i*TGA_W +: TGA_W])) begin
                found = 1'b1;
                idx_o = IDX_W'(i);
            end
        end
        sel_o = NSLV'(1) << idx_o;
    end

endmodule

// File: rtl/z80_wb_router.sv
// rtl/z80_wb_router.sv - Wishbone classic router from the z80 master to NSLV slaves
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-low reset
//   wb_adr/dat/we/cyc/stb/tga_i master request
//   wb_dat_o, wb_ack_o, wb_err_o master response
//   s_cyc_o, s_stb_o            one-hot per-slave cycle/strobe
//   s_we/adr/dat/tga_o          broadcast copies of the master request
//   s_dat_i, s_ack_i, s_err_i   packed slave responses (slot0 in LSBs)
//   err_vld_o, err_adr_o        sticky first-error flag and address
//   err_clr_i                   clears the sticky error record
module z80_wb_router
    import z80_wb_router_pkg::*;
#(
    parameter int                      NSLV     = 3,
    parameter int                      ADR_W    = 16,
    parameter int                      DAT_W    = 8,
    parameter int                      TGA_W    = 2,
    parameter logic [NSLV*ADR_W-1:0]   SLV_BASE = {16'h0000, 16'h0000, 16'h0000},
    parameter logic [NSLV*ADR_W-1:0]   SLV_MASK = {16'h0000, 16'h0000, 16'h8000},
    parameter logic [NSLV*TGA_W-1:0]   SLV_TGA  = {TGA_MEM, TGA_IO, TGA_MEM},
    parameter int                      TIMEOUT  = 255,
    parameter int                      REG_RSP  = 0
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic [ADR_W-1:0]       wb_adr_i,
    input  logic [DAT_W-1:0]       wb_dat_i,
    input  logic                   wb_we_i,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic [TGA_W-1:0]       wb_tga_i,
    output logic [DAT_W-1:0]       wb_dat_o,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic [NSLV-1:0]        s_cyc_o,
    output logic [NSLV-1:0]        s_stb_o,
    output logic                   s_we_o,
    output logic [ADR_W-1:0]       s_adr_o,
    output logic [DAT_W-1:0]       s_dat_o,
    output logic [TGA_W-1:0]       s_tga_o,
    input  logic [NSLV*DAT_W-1:0]  s_dat_i,
    input  logic [NSLV-1:0]        s_ack_i,
    input  logic [NSLV-1:0]        s_err_i,
    output logic                   err_vld_o,
    output logic [ADR_W-1:0]       err_adr_o,
    input  logic                   err_clr_i
);

    localparam int               IDX_W    = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   sel_q, sel_d;
    logic               rsp_ack_q, rsp_ack_d;
    logic               rsp_err_q, rsp_err_d;
    logic [DAT_W-1:0]   rsp_dat_q, rsp_dat_d;
    logic               err_vld_q, err_vld_d;
    logic [ADR_W-1:0]   err_adr_q, err_adr_d;

    logic [NSLV-1:0]    dec_sel;
    logic [IDX_W-1:0]   dec_idx;
    logic [IDX_W-1:0]   act_idx;
    logic [NSLV-1:0]    act_sel;
    logic               live, drive, err_ev;
    logic               sl_ack, sl_err;
    logic [DAT_W-1:0]   sl_dat;

    z80_wb_addr_dec #(
        .NSLV  (NSLV),
        .ADR_W (ADR_W),
        .TGA_W (TGA_W),
        .IDX_W (IDX_W),
        .BASE  (SLV_BASE),
        .MASK  (SLV_MASK),
        .TGA   (SLV_TGA)
    ) u_dec (
        .adr_i (wb_adr_i),
        .tga_i (wb_tga_i),
        .sel_o (dec_sel),
        .idx_o (dec_idx)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        sel_d     = sel_q;
        rsp_ack_d = 1'b0;
        rsp_err_d = 1'b0;
        rsp_dat_d = '0;
        drive     = 1'b0;
        err_ev    = 1'b0;
        wb_ack_o  = 1'b0;
        wb_err_o  = 1'b0;
        wb_dat_o  = '0;

        // IDLE routes on the live decode; BUSY holds the latched slot
        act_idx = (state_q == ST_IDLE) ? dec_idx : sel_q;
        act_sel = (state_q == ST_IDLE) ? dec_sel : (NSLV'(1) << sel_q);
        sl_ack  = s_ack_i[act_idx];
        sl_err  = s_err_i[act_idx];
        sl_dat  = s_dat_i[act_idx*DAT_W +: DAT_W];
        live    = wb_cyc_i && wb_stb_i;

        case (state_q)
            ST_IDLE, ST_BUSY: begin
                if (!live) begin
                    state_d = ST_IDLE;
                end else begin
                    drive = 1'b1;
                    if (sl_err || sl_ack) begin
                        // Slave error outranks a simultaneous ack
                        err_ev = sl_err;
                        if (REG_RSP != 0) begin
                            rsp_ack_d = !sl_err;
                            rsp_err_d = sl_err;
                            rsp_dat_d = sl_err ? '0 : sl_dat;
                            state_d   = ST_RESP;
                        end else begin
                            wb_ack_o = !sl_err;
                            wb_err_o = sl_err;
                            wb_dat_o = sl_err ? '0 : sl_dat;
                            state_d  = ST_IDLE;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        wb_err_o = 1'b1;
                        err_ev   = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_BUSY;
                        sel_d   = act_idx;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // A master that already dropped cyc sees no response
                if (wb_cyc_i) begin
                    wb_ack_o = rsp_ack_q;
                    wb_err_o = rsp_err_q;
                    wb_dat_o = rsp_dat_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        s_cyc_o = drive ? act_sel : '0;
        s_stb_o = drive ? act_sel : '0;
        s_we_o  = wb_we_i;
        s_adr_o = wb_adr_i;
        s_dat_o = wb_dat_i;
        s_tga_o = wb_tga_i;

        // Reset forces every output low immediately, without waiting for a clock
        if (!wb_rst_i) begin
            s_cyc_o  = '0;
            s_stb_o  = '0;
            s_we_o   = 1'b0;
            s_adr_o  = '0;
            s_dat_o  = '0;
            s_tga_o  = '0;
            wb_ack_o = 1'b0;
            wb_err_o = 1'b0;
            wb_dat_o = '0;
        end

        // Clear beats a coincident new error; only the first error is recorded
        err_vld_d = err_vld_q;
        err_adr_d = err_adr_q;
        if (err_clr_i) begin
            err_vld_d = 1'b0;
            err_adr_d = '0;
        end else if (err_ev && !err_vld_q) begin
            err_vld_d = 1'b1;
            err_adr_d = wb_adr_i;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sel_q     <= '0;
            rsp_ack_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_dat_q <= '0;
            err_vld_q <= 1'b0;
            err_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sel_q     <= sel_d;
            rsp_ack_q <= rsp_ack_d;
            rsp_err_q <= rsp_err_d;
            rsp_dat_q <= rsp_dat_d;
            err_vld_q <= err_vld_d;
            err_adr_q <= err_adr_d;
        end
    end

    assign err_vld_o = err_vld_q;
    assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_z80_wb_router.sv
// tb/tb_z80_wb_router.sv - directed self-checking bench for z80_wb_router
module tb_z80_wb_router;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] adr = '0;
    logic [7:0]  wdat = '0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, err_clr = 1'b0;
    logic [1:0]  tga = '0;
    logic [23:0] s_dat = '0;
    logic [2:0]  s_ack = '0, s_err = '0;

    logic [7:0]  a_dat, b_dat;
    logic        a_ack, a_err, b_ack, b_err;
    logic [2:0]  a_s_cyc, a_s_stb, b_s_cyc, b_s_stb;
    logic        a_s_we, b_s_we;
    logic [15:0] a_s_adr, b_s_adr;
    logic [7:0]  a_s_dat, b_s_dat;
    logic [1:0]  a_s_tga, b_s_tga;
    logic        a_err_vld, b_err_vld;
    logic [15:0] a_err_adr, b_err_adr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    z80_wb_router #(.TIMEOUT(8), .REG_RSP(0)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_tga_i(tga),
        .wb_dat_o(a_dat), .wb_ack_o(a_ack), .wb_err_o(a_err),
        .s_cyc_o(a_s_cyc), .s_stb_o(a_s_stb), .s_we_o(a_s_we), .s_adr_o(a_s_adr),
        .s_dat_o(a_s_dat), .s_tga_o(a_s_tga), .s_dat_i(s_dat), .s_ack_i(s_ack),
        .s_err_i(s_err), .err_vld_o(a_err_vld), .err_adr_o(a_err_adr), .err_clr_i(err_clr)
    );

    z80_wb_router #(.TIMEOUT(8), .REG_RSP(1)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst_n), .wb_adr_i(adr), .wb_dat_i(wdat),
        .wb_we_i(we), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_tga_i(tga),
        .wb_dat_o(b_dat), .wb_ack_o(b_ack), .wb_err_o(b_err),
        .s_cyc_o(b_s_cyc), .s_stb_o(b_s_stb), .s_we_o(b_s_we), .s_adr_o(b_s_adr),
        .s_dat_o(b_s_dat), .s_tga_o(b_s_tga), .s_dat_i(s_dat), .s_ack_i(s_ack),
        .s_err_i(s_err), .err_vld_o(b_err_vld), .err_adr_o(b_err_adr), .err_clr_i(err_clr)
    );

    task automatic go_idle();
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; s_ack = '0; s_err = '0; s_dat = '0; err_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        adr = 16'h1234; cyc = 1'b1; stb = 1'b1; s_ack = 3'b001; s_dat = 24'h0000A5;
        #1;
        n_checks++; if (a_s_stb !== 3'b000) begin n_fail++; $display("FAIL reset_s_stb: got %b exp 000", a_s_stb); end
        n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b exp 0", a_ack); end
        n_checks++; if (a_dat !== 8'h00) begin n_fail++; $display("FAIL reset_dat: got %h exp 00", a_dat); end
        n_checks++; if (a_s_adr !== 16'h0000) begin n_fail++; $display("FAIL reset_s_adr: got %h exp 0000", a_s_adr); end
        n_checks++; if (a_err_vld !== 1'b0) begin n_fail++; $display("FAIL reset_err_vld: got %b exp 0", a_err_vld); end
        n_checks++; if (a_err_adr !== 16'h0000) begin n_fail++; $display("FAIL reset_err_adr: got %h exp 0000", a_err_adr); end
        cyc = 1'b0; stb = 1'b0; s_ack = '0; s_dat = '0; adr = '0;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_read_same_cycle();
        @(posedge clk); #1;
        adr = 16'h1234; tga = 2'b00; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        s_ack = 3'b001; s_dat = 24'h0000A5;
        @(negedge clk);
        n_checks++; if (a_s_stb !== 3'b001) begin n_fail++; $display("FAIL t1_s_stb: got %b exp 001", a_s_stb); end
        n_checks++; if (a_s_cyc !== 3'b001) begin n_fail++; $display("FAIL t1_s_cyc: got %b exp 001", a_s_cyc); end
        n_checks++; if (a_ack !== 1'b1) begin n_fail++; $display("FAIL t1_ack: got %b exp 1", a_ack); end
        n_checks++; if (a_dat !== 8'hA5) begin n_fail++; $display("FAIL t1_dat: got %h exp a5", a_dat); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL t1_err: got %b exp 0", a_err); end
        n_checks++; if (a_s_adr !== 16'h1234) begin n_fail++; $display("FAIL t1_s_adr: got %h exp 1234", a_s_adr); end
        go_idle();
    endtask

    task automatic test_decode();
        @(posedge clk); #1;
        adr = 16'h8000; tga = 2'b00; cyc = 1'b1; stb = 1'b1; s_ack = 3'b100; s_dat = 24'h5A0000;
        @(negedge clk);
        n_checks++; if (a_s_stb !== 3'b100) begin n_fail++; $display("FAIL t2_mem_hi_sel: got %b exp 100", a_s_stb); end
        n_checks++; if (a_dat !== 8'h5A) begin n_fail++; $display("FAIL t2_mem_hi_dat: got %h exp 5a", a_dat); end
        @(posedge clk); #1;
        adr = 16'h0010; tga = 2'b01; s_ack = 3'b010; s_dat = 24'h00C300;
        @(negedge clk);
        n_checks++; if (a_s_stb !== 3'b010) begin n_fail++; $display("FAIL t2_io_sel: got %b exp 010", a_s_stb); end
        n_checks++; if (a_dat !== 8'hC3) begin n_fail++; $display("FAIL t2_io_dat: got %h exp c3", a_dat); end
        @(posedge clk); #1;
        adr = 16'h0010; tga = 2'b10; s_ack = 3'b100; s_dat = 24'h770000;
        @(negedge clk);
        n_checks++; if (a_s_stb !== 3'b100) begin n_fail++; $display("FAIL t2_intack_sel: got %b exp 100", a_s_stb); end
        n_checks++; if (a_dat !== 8'h77) begin n_fail++; $display("FAIL t2_intack_dat: got %h exp 77", a_dat); end
        tga = 2'b00;
        go_idle();
    endtask

    task automatic test_timeout();
        @(posedge clk); #1;
        adr = 16'h4321; tga = 2'b00; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++; if (a_err !== 1'(k == 8)) begin n_fail++; $display("FAIL t3_err_cyc%0d: got %b exp %b", k, a_err, (k == 8)); end
            n_checks++; if (a_s_stb !== 3'b001) begin n_fail++; $display("FAIL t3_s_stb_cyc%0d: got %b exp 001", k, a_s_stb); end
        end
        n_checks++; if (b_err !== 1'b1) begin n_fail++; $display("FAIL t3_regrsp_err: got %b exp 1", b_err); end
        n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL t3_ack: got %b exp 0", a_ack); end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_checks++; if (a_s_stb !== 3'b000) begin n_fail++; $display("FAIL t3_s_stb_after: got %b exp 000", a_s_stb); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL t3_err_after: got %b exp 0", a_err); end
        n_checks++; if (a_err_vld !== 1'b1) begin n_fail++; $display("FAIL t3_err_vld: got %b exp 1", a_err_vld); end
        n_checks++; if (a_err_adr !== 16'h4321) begin n_fail++; $display("FAIL t3_err_adr: got %h exp 4321", a_err_adr); end
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        @(negedge clk);
        n_checks++; if (a_err_vld !== 1'b0) begin n_fail++; $display("FAIL t3_clr_vld: got %b exp 0", a_err_vld); end
        n_checks++; if (a_err_adr !== 16'h0000) begin n_fail++; $display("FAIL t3_clr_adr: got %h exp 0000", a_err_adr); end
        go_idle();
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        adr = 16'h1111; cyc = 1'b1; stb = 1'b1;
        repeat (3) @(posedge clk);
        #1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL t4_abort_ack: got %b exp 0", a_ack); end
        n_checks++; if (a_err !== 1'b0) begin n_fail++; $display("FAIL t4_abort_err: got %b exp 0", a_err); end
        n_checks++; if (a_s_cyc !== 3'b000) begin n_fail++; $display("FAIL t4_abort_s_cyc: got %b exp 000", a_s_cyc); end
        @(posedge clk); #1;
        adr = 16'h2222; cyc = 1'b1; stb = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            n_checks++; if (a_err !== 1'(k == 8)) begin n_fail++; $display("FAIL t4_full_tmo_cyc%0d: got %b exp %b", k, a_err, (k == 8)); end
        end
        @(posedge clk); #1; cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_checks++; if (a_err_adr !== 16'h2222) begin n_fail++; $display("FAIL t4_err_adr: got %h exp 2222", a_err_adr); end
        @(posedge clk); #1; err_clr = 1'b1;
        go_idle();
    endtask

    task automatic test_slave_err_sticky();
        @(posedge clk); #1;
        adr = 16'h0222; cyc = 1'b1; stb = 1'b1; s_ack = 3'b001; s_err = 3'b001; s_dat = 24'h000099;
        @(negedge clk);
        n_checks++; if (a_err !== 1'b1) begin n_fail++; $display("FAIL t6_both_err: got %b exp 1", a_err); end
        n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL t6_both_ack: got %b exp 0", a_ack); end
        n_checks++; if (a_dat !== 8'h00) begin n_fail++; $display("FAIL t6_both_dat: got %h exp 00", a_dat); end
        @(posedge clk); #1;
        adr = 16'h0333; s_ack = 3'b000;
        @(posedge clk); #1;
        adr = 16'h0444; err_clr = 1'b1;
        @(negedge clk);
        n_checks++; if (a_err_vld !== 1'b1) begin n_fail++; $display("FAIL t6_sticky_vld: got %b exp 1", a_err_vld); end
        n_checks++; if (a_err_adr !== 16'h0222) begin n_fail++; $display("FAIL t6_sticky_adr: got %h exp 0222", a_err_adr); end
        @(posedge clk); #1;
        err_clr = 1'b0; adr = 16'h0555;
        @(negedge clk);
        n_checks++; if (a_err_vld !== 1'b0) begin n_fail++; $display("FAIL t6_clr_wins: got %b exp 0", a_err_vld); end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; s_err = '0;
        @(negedge clk);
        n_checks++; if (a_err_adr !== 16'h0555) begin n_fail++; $display("FAIL t6_reload_adr: got %h exp 0555", a_err_adr); end
        go_idle();
    endtask

    task automatic test_reg_rsp();
        @(posedge clk); #1;
        adr = 16'h0040; tga = 2'b00; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        n_checks++; if (b_s_stb !== 3'b001) begin n_fail++; $display("FAIL t5_c1_s_stb: got %b exp 001", b_s_stb); end
        @(posedge clk); #1;
        s_ack = 3'b001; s_dat = 24'h00003C;
        @(negedge clk);
        n_checks++; if (b_ack !== 1'b0) begin n_fail++; $display("FAIL t5_c2_ack: got %b exp 0", b_ack); end
        @(posedge clk); #1;
        s_ack = 3'b000; s_dat = 24'h000000;
        @(negedge clk);
        n_checks++; if (b_s_stb !== 3'b000) begin n_fail++; $display("FAIL t5_c3_s_stb: got %b exp 000", b_s_stb); end
        n_checks++; if (b_ack !== 1'b1) begin n_fail++; $display("FAIL t5_c3_ack: got %b exp 1", b_ack); end
        n_checks++; if (b_dat !== 8'h3C) begin n_fail++; $display("FAIL t5_c3_dat: got %h exp 3c", b_dat); end
        n_checks++; if (b_err !== 1'b0) begin n_fail++; $display("FAIL t5_c3_err: got %b exp 0", b_err); end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        n_checks++; if (b_ack !== 1'b0) begin n_fail++; $display("FAIL t5_c4_ack: got %b exp 0", b_ack); end
        go_idle();
    endtask

    task automatic test_reset_mid_busy();
        @(posedge clk); #1;
        adr = 16'h0050; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (a_s_stb !== 3'b001) begin n_fail++; $display("FAIL t6_busy_s_stb: got %b exp 001", a_s_stb); end
        #1;
        s_ack = 3'b001; s_dat = 24'h0000EE; rst_n = 1'b0;
        #1;
        n_checks++; if (a_s_stb !== 3'b000) begin n_fail++; $display("FAIL t6_rst_s_stb: got %b exp 000", a_s_stb); end
        n_checks++; if (a_s_cyc !== 3'b000) begin n_fail++; $display("FAIL t6_rst_s_cyc: got %b exp 000", a_s_cyc); end
        n_checks++; if (a_ack !== 1'b0) begin n_fail++; $display("FAIL t6_rst_ack: got %b exp 0", a_ack); end
        n_checks++; if (a_dat !== 8'h00) begin n_fail++; $display("FAIL t6_rst_dat: got %h exp 00", a_dat); end
        n_checks++; if (a_s_adr !== 16'h0000) begin n_fail++; $display("FAIL t6_rst_s_adr: got %h exp 0000", a_s_adr); end
        n_checks++; if (a_err_vld !== 1'b0) begin n_fail++; $display("FAIL t6_rst_err_vld: got %b exp 0", a_err_vld); end
        n_checks++; if (a_err_adr !== 16'h0000) begin n_fail++; $display("FAIL t6_rst_err_adr: got %h exp 0000", a_err_adr); end
        cyc = 1'b0; stb = 1'b0; s_ack = '0; s_dat = '0;
        @(negedge clk); rst_n = 1'b1;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_read_same_cycle();
        test_decode();
        test_timeout();
        test_abort();
        test_slave_err_sticky();
        test_reg_rsp();
        test_reset_mid_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
